// File: rtl/md_pkg.sv
// md_pkg: shared op encodings and latency defaults for the multiply/divide scheduler.
package md_pkg;
  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  function automatic logic md_is_start(input md_op_e op);
    return op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/muldiv_arith.sv
// muldiv_arith: combinational 32x32 multiply and divide, signed or unsigned.
module muldiv_arith (
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur;
  logic [63:0] a_x, b_x;
  always_comb begin
    a_neg    = is_signed & a[31];
    b_neg    = is_signed & b[31];
    a_x      = {{32{a_neg}}, a};
    b_x      = {{32{b_neg}}, b};
    prod     = a_x * b_x;
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = b == 32'd0;
    // Divide magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
    b_safe   = div_zero ? 32'd1 : b_mag;
    uq       = a_mag / b_safe;
    ur       = a_mag % b_safe;
    quot     = (a_neg ^ b_neg) ? -uq : uq;
    rem      = a_neg ? -ur : ur;
  end
endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: multi-cycle mult/div scheduler owning HI/LO, with D-stage stall request.
module muldiv_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op_E,
  input  logic [31:0] a_E,
  input  logic [31:0] b_E,
  input  logic        md_use_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_D
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);

  md_op_e      op;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d, hi_q, hi_d, lo_q, lo_d;
  logic        pend_valid_q, pend_valid_d;
  logic [63:0] prod;
  logic [31:0] quot, rem;
  logic        div_zero;

  assign op = md_op_e'(op_E);

  muldiv_arith u_arith (
    .is_signed(op == MD_MULT || op == MD_DIV),
    .a        (a_E),
    .b        (b_E),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always_comb begin
    cnt_d        = cnt_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    if (cnt_q == '0) begin
      case (op)
        MD_MULT, MD_MULTU: begin
          cnt_d        = CW'(MULT_CYCLES);
          {pend_hi_d, pend_lo_d} = prod;
          pend_valid_d = 1'b1;
        end
        MD_DIV, MD_DIVU: begin
          cnt_d        = CW'(DIV_CYCLES);
          pend_hi_d    = rem;
          pend_lo_d    = quot;
          pend_valid_d = !div_zero;
        end
        MD_MTHI: hi_d = a_E;
        MD_MTLO: lo_d = a_E;
        default: ;
      endcase
    end else begin
      // Ops arriving while busy are dropped; the hazard unit should never send one.
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        hi_d         = pend_valid_q ? pend_hi_q : hi_q;
        lo_d         = pend_valid_q ? pend_lo_q : lo_q;
        pend_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      pend_hi_q    <= '0;
      pend_lo_q    <= '0;
      pend_valid_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      cnt_q        <= cnt_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = cnt_q != '0;
  assign stall_D = md_use_D && (busy || md_is_start(op));
endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: table-driven check of muldiv_sched plus stall/reset sequences.
module tb_muldiv_sched;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  op_E = 3'd0;
  logic [31:0] a_E = '0, b_E = '0;
  logic        md_use_D = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall_D;
  int          checks = 0;
  int          failures = 0;

  muldiv_sched dut (
    .clk     (clk),
    .reset   (reset),
    .op_E    (op_E),
    .a_E     (a_E),
    .b_E     (b_E),
    .md_use_D(md_use_D),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall_D (stall_D)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cycles,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n = 0;
    @(negedge clk);
    op_E = op; a_E = a; b_E = b;
    @(negedge clk);
    op_E = MD_NONE; a_E = '0; b_E = '0;
    repeat (cycles + 3) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, n, cycles);
    check({name, " busy_end"}, {31'd0, busy}, 32'd0);
    check({name, " hi"}, hi, exp_hi);
    check({name, " lo"}, lo, exp_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'h2,        5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h2,        5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_DIVU,  32'h7,        32'h2,        10, 32'h00000001, 32'h00000003};
    vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[5]  = '{MD_MTHI,  32'hAAAA0000, 32'h0,        0,  32'hAAAA0000, 32'h80000000};
    vecs[6]  = '{MD_MTLO,  32'h00005555, 32'h0,        0,  32'hAAAA0000, 32'h00005555};
    vecs[7]  = '{MD_DIVU,  32'h7,        32'h0,        10, 32'hAAAA0000, 32'h00005555};
    vecs[8]  = '{MD_MTHI,  32'h12345678, 32'h0,        0,  32'h12345678, 32'h00005555};
    vecs[9]  = '{MD_MULT,  32'h3,        32'h4,        5,  32'h00000000, 32'h0000000C};
    vecs[10] = '{MD_DIV,   32'h7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[11] = '{MD_RSVD,  32'hDEADBEEF, 32'h1,        0,  32'h00000001, 32'hFFFFFFFD};

    // Reset state, and stall_D combinational even while reset is held.
    md_use_D = 1'b1;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset stall none", {31'd0, stall_D}, 32'd0);
    op_E = MD_DIV;
    #1;
    check("reset stall div", {31'd0, stall_D}, 32'd1);
    op_E = MD_MTHI;
    #1;
    check("reset stall mthi", {31'd0, stall_D}, 32'd0);
    op_E = MD_NONE;
    md_use_D = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].cycles, vecs[i].exp_hi, vecs[i].exp_lo);

    // Stall through a mult; mtlo offered mid-busy must be ignored.
    @(negedge clk);
    md_use_D = 1'b1; op_E = MD_MULT; a_E = 32'd2; b_E = 32'd3;
    #1;
    check("stall issue", {31'd0, stall_D}, 32'd1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      op_E = (k == 2) ? MD_MTLO : MD_NONE;
      a_E  = (k == 2) ? 32'hDEAD0000 : 32'd0;
      md_use_D = (k != 4);
      #1;
      check($sformatf("stall k%0d", k), {31'd0, stall_D}, (k == 4 || k == 6) ? 32'd0 : 32'd1);
      if (k == 3) check("mtlo while busy", lo, 32'hFFFFFFFD);
    end
    check("stall mult hi", hi, 32'd0);
    check("stall mult lo", lo, 32'd6);
    md_use_D = 1'b0;

    // Reset in the middle of a divide.
    @(negedge clk);
    op_E = MD_DIV; a_E = 32'd100; b_E = 32'd7;
    @(negedge clk);
    op_E = MD_NONE;
    repeat (3) @(negedge clk);
    check("mid busy before reset", {31'd0, busy}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("mid reset busy", {31'd0, busy}, 32'd0);
    check("mid reset hi", hi, 32'd0);
    check("mid reset lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op("post reset mult", MD_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multi-cycle multiply/divide scheduler and HI/LO register owner for the five-stage pipeline. Accepts mult/multu/div/divu/mthi/mtlo from the E stage, runs a cycle counter for the fixed unit latency, and commits results to HI/LO at completion. Raises a D-stage stall whenever the D-stage instruction needs HI/LO while an operation is issuing or in flight; the existing hazard unit ORs this into its PC/FD-enable and DE-clear logic.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- op_E  in  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- a_E  in  32  forwarded rs value (M_RD1_E)
- b_E  in  32  forwarded rt value (M_RD2_E)
- md_use_D  in  1  D-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  operation in flight
- stall_D  out  1  stall request to hazard unit

## Operation
- States: IDLE (cnt==0), BUSY (cnt!=0); busy = (cnt!=0); cnt width = clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- IDLE, op_E mult/multu: cnt<=MULT_CYCLES; pend_hi/pend_lo <= 64-bit product; mult signed, multu unsigned; {pend_hi,pend_lo} = full product.
- IDLE, op_E div/divu: cnt<=DIV_CYCLES; pend_lo<=quotient, pend_hi<=remainder; div signed, truncates toward zero, remainder takes dividend sign; divu unsigned.
- Divisor zero: full DIV_CYCLES busy period, HI/LO unchanged at completion (pend_valid cleared).
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- IDLE, op_E mthi: hi<=a_E at that edge; mtlo: lo<=a_E; no busy.
- BUSY: cnt decrements each edge; at edge where cnt==1, hi/lo<=pend_hi/pend_lo (if pend_valid), cnt<=0.
- Any op_E other than none while BUSY is ignored (hazard unit guarantees none arrives; ignoring is defensive).
- stall_D = md_use_D && (busy || op_E in {1,2,3,4}); purely combinational.
- mfhi/mflo read hi/lo outputs directly; no forwarding needed because of stall_D.

## Timing
- Reset (async, low): cnt=0, busy=0, hi=0, lo=0, pend_*=0, stall_D=md_use_D && op_E start (combinational only).
- Issue edge t0: busy high for exactly N cycles (t0..t0+N); hi/lo updated at edge t0+N; busy low in same cycle new hi/lo visible.
- mfhi in D during last busy cycle: stalled; released next cycle, reads committed value.
- Back-to-back: new op may issue at edge t0+N (cnt==1 cycle is still BUSY -> ignored); earliest next issue is edge t0+N+1.
- mthi/mtlo visible on hi/lo one cycle after sampled edge.
- Reset mid-operation: pending result discarded, HI/LO zero immediately.

## Structure
- Shared package md_pkg: op encodings (MD_NONE..MD_MTLO), MULT_CYCLES/DIV_CYCLES defaults.
- Sub-module muldiv_arith: combinational signed/unsigned 64-bit product, quotient, remainder, div-by-zero flag; scheduler holds counter, pending and HI/LO registers.

## Test plan
- mult a=0xFFFFFFFF b=0x00000002 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE; multu same -> hi=0x00000001 lo=0xFFFFFFFE.
- div a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF; divu 7/2 -> lo=3 hi=1; div 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
- divu 7/0 after hi=0xAAAA0000 lo=0x5555 -> busy 10 cycles, hi/lo unchanged.
- md_use_D=1 with op_E=mult -> stall_D=1 same cycle, stays 1 through busy, 0 cycle after last busy; md_use_D=0 during busy -> stall_D=0.
- mthi a=0x12345678 -> hi=0x12345678 next cycle, busy=0; mtlo presented while busy -> lo unchanged.
- reset low at cycle 4 of div -> busy=0, hi=lo=0 without clock edge; after release, mult 3*4 -> lo=12 after 5 cycles.
